// File: rtl/scan_sel_seq.sv
// Channel-scan sequencer driving a 4-to-16 one-hot decoder.
// Walks enabled mask bits with programmable dwell and a one-cycle blank.
module scan_sel_seq #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [15:0]        mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [3:0]         sel,
  output logic               sel_en,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    BLANK  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           sel_q, sel_d;
  logic                 en_q, en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [15:0]          mask_q, mask_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic                 mode_q, mode_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [15:0]          above;
  logic                 fin;

  function automatic logic [3:0] lowest(input logic [15:0] m);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // captured channels strictly above the current one
  assign above = mask_q & (16'hFFFF << ({1'b0, sel_q} + 5'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mask_q  <= '0;
      dwell_q <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mask_q  <= mask_d;
      dwell_q <= dwell_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    mask_d  = mask_q;
    dwell_d = dwell_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    fin     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          if (|mask) begin
            mask_d  = mask;
            dwell_d = (dwell == '0) ? DWELL_W'(1) : dwell;
            mode_d  = mode;
            sel_d   = lowest(mask);
            cnt_d   = DWELL_W'(1);
            state_d = ACTIVE;
            en_d    = 1'b1;
            busy_d  = 1'b1;
          end else if (!done_q) begin
            // held start on an empty mask must not repeat done
            done_d = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (stop) begin
          fin = 1'b1;
        end else if (cnt_q >= dwell_q) begin
          state_d = BLANK;
          en_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end
      BLANK: begin
        if (stop) begin
          fin = 1'b1;
        end else if (|above) begin
          sel_d   = lowest(above);
          cnt_d   = DWELL_W'(1);
          state_d = ACTIVE;
          en_d    = 1'b1;
        end else if (mode_q && |mask) begin
          mask_d  = mask;
          sel_d   = lowest(mask);
          cnt_d   = DWELL_W'(1);
          state_d = ACTIVE;
          en_d    = 1'b1;
        end else begin
          fin = 1'b1;
        end
      end
      default: begin
        fin = 1'b1;
      end
    endcase
    if (fin) begin
      state_d = IDLE;
      sel_d   = '0;
      en_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end
  end

  assign sel    = sel_q;
  assign sel_en = en_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_scan_sel_seq.sv
// Bench for scan_sel_seq: directed plan cases plus random stimulus
// compared cycle by cycle against a channel-list reference model.
module tb_scan_sel_seq;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          mode = 1'b0;
  logic [15:0]   mask = '0;
  logic [DW-1:0] dwell = '0;
  logic [3:0]    sel;
  logic          sel_en;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  int pend[$];
  bit m_busy, m_done, m_mode;
  int m_ch, m_pos, m_dw;

  always #5 clk = ~clk;

  scan_sel_seq #(.DWELL_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .mode(mode), .mask(mask), .dwell(dwell),
    .sel(sel), .sel_en(sel_en), .busy(busy), .done(done)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    m_busy = 0; m_done = 0; m_mode = 0;
    m_ch = 0; m_pos = 0; m_dw = 1;
  endtask

  task automatic fill(input logic [15:0] m);
    pend.delete();
    for (int i = 0; i < 16; i++)
      if (m[i]) pend.push_back(i);
  endtask

  task automatic end_scan();
    pend.delete();
    m_busy = 0; m_ch = 0; m_done = 1;
  endtask

  // Each channel is a slot of dwell'+1 cycles; the last one is blank.
  task automatic model_step();
    bit prev_done;
    prev_done = m_done;
    m_done = 0;
    if (m_busy) begin
      if (stop) begin
        end_scan();
      end else begin
        m_pos++;
        if (m_pos > m_dw) begin
          m_pos = 0;
          if (pend.size() > 0) begin
            m_ch = pend.pop_front();
          end else if (m_mode && mask != 0) begin
            fill(mask);
            m_ch = pend.pop_front();
          end else begin
            end_scan();
          end
        end
      end
    end else if (start && !stop) begin
      if (mask != 0) begin
        fill(mask);
        m_ch = pend.pop_front();
        m_busy = 1; m_pos = 0;
        m_dw = (dwell == 0) ? 1 : int'(dwell);
        m_mode = mode;
      end else if (!prev_done) begin
        m_done = 1;
      end
    end
  endtask

  task automatic compare();
    check("sel", 32'(sel), 32'(m_ch));
    check("sel_en", 32'(sel_en), 32'(m_busy && m_pos < m_dw));
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(m_done));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  initial begin
    int exp_sel[10];
    int exp_en[10];
    exp_sel = '{0, 0, 0, 3, 3, 3, 7, 7, 7, 0};
    exp_en  = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 0};
    model_reset();

    @(negedge clk);
    check("rst_sel", 32'(sel), 0);
    check("rst_en", 32'(sel_en), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    rst_n = 1'b1;
    repeat (2) cyc();

    // single pass 0x0089, dwell 2
    mask = 16'h0089; dwell = 2; mode = 0; start = 1;
    for (int c = 1; c <= 10; c++) begin
      cyc();
      start = 0;
      check("p1_sel", 32'(sel), 32'(exp_sel[c-1]));
      check("p1_en", 32'(sel_en), 32'(exp_en[c-1]));
    end
    check("p1_done", 32'(done), 1);
    check("p1_busy", 32'(busy), 0);
    cyc();

    // continuous 0x8001, dwell 0
    mask = 16'h8001; dwell = 0; mode = 1; start = 1;
    cyc();
    start = 0;
    repeat (9) cyc();
    stop = 1; cyc(); stop = 0;
    cyc();

    // continuous single channel, mask cleared mid-pass
    mask = 16'h0010; dwell = 2; mode = 1; start = 1;
    cyc();
    start = 0; mask = 16'h0000;
    repeat (2) cyc();
    check("wrap_blank_sel", 32'(sel), 4);
    cyc();
    check("wrap_done", 32'(done), 1);
    check("wrap_busy", 32'(busy), 0);
    cyc();

    // stop in second dwell cycle of channel 3
    mask = 16'h0089; dwell = 4; mode = 0; start = 1;
    cyc();
    start = 0;
    repeat (6) cyc();
    check("stop_pre_sel", 32'(sel), 3);
    stop = 1; cyc(); stop = 0;
    check("stop_en", 32'(sel_en), 0);
    check("stop_sel", 32'(sel), 0);
    check("stop_done", 32'(done), 1);
    cyc();
    check("stop_done2", 32'(done), 0);

    // empty-mask start, then start pulsed while busy
    mask = 16'h0000; start = 1;
    cyc();
    start = 0;
    check("empty_done", 32'(done), 1);
    check("empty_busy", 32'(busy), 0);
    cyc();
    mask = 16'h0c02; dwell = 1; mode = 0; start = 1;
    cyc();
    start = 0; cyc();
    mask = 16'h0001; start = 1; cyc(); start = 0;
    repeat (8) cyc();

    // asynchronous reset mid-ACTIVE
    mask = 16'hffff; dwell = 5; mode = 1; start = 1;
    cyc();
    start = 0; cyc();
    #2 rst_n = 1'b0;
    #1;
    check("arst_sel", 32'(sel), 0);
    check("arst_en", 32'(sel_en), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_done", 32'(done), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) cyc();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 9) == 0) mode = 1'($urandom);
      if ($urandom_range(0, 11) == 0) begin
        case ($urandom_range(0, 3))
          0: mask = 16'h0000;
          1: mask = 16'(1 << $urandom_range(0, 15));
          default: mask = 16'($urandom) & 16'($urandom);
        endcase
      end
      if ($urandom_range(0, 7) == 0) dwell = DW'($urandom_range(0, 3));
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_sel_seq.md
# scan_sel_seq

Channel-scan sequencer sitting directly upstream of the 4-to-16 one-hot decoder. It walks through the channels enabled in a 16-bit mask and drives the decoder's 4-bit select and enable inputs, holding each channel for a programmable dwell time. A one-cycle break-before-make blank separates consecutive channels. Both single-pass and continuous scanning are supported, with start, stop and done control.

## Interface
Parameters:
- DWELL_W, 8, width of the dwell-count input and internal dwell counter

Ports:
- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  begin scan; honoured only in IDLE
- stop  input  1  abort scan; highest priority
- mode  input  1  0 = single pass, 1 = continuous
- mask  input  16  channel enables; bit i enables channel i
- dwell  input  DWELL_W  cycles each channel is held; 0 is treated as 1
- sel  output  4  channel index to decoder d[3:0]
- sel_en  output  1  decoder enable
- busy  output  1  high while a scan is in progress
- done  output  1  one-cycle pulse at scan end (pass complete, empty mask, or stop)

## Operation
- Reset values: sel=0, sel_en=0, busy=0, done=0, state IDLE, internal mask/dwell/mode registers 0. Reset is asynchronous: outputs clear immediately on rst_n low, including mid-scan.
- States: IDLE, ACTIVE, BLANK.
- IDLE:
  - start=1, stop=0, mask!=0: capture mask, dwell (0 becomes 1) and mode; load sel with the lowest set bit of mask; go to ACTIVE.
  - start=1, mask==0: stay in IDLE; done=1 for the next cycle.
  - start=1 with stop=1: no action and no done.
- ACTIVE: sel_en=1, busy=1. The dwell counter counts the captured dwell cycles, then the state goes to BLANK.
- BLANK: exactly one cycle with sel_en=0 and sel held. The next channel is the lowest set bit of the captured mask with index greater than sel, found by a combinational search in the same cycle.
  - Next channel found: load sel, go to ACTIVE.
  - None found, mode=1 (wrap): re-sample the live mask. If it is nonzero, load its lowest set bit and go to ACTIVE. If it is zero, go to IDLE with done.
  - None found, mode=0: go to IDLE with done.
- stop=1 in ACTIVE or BLANK: next cycle state IDLE, sel_en=0, sel=0, busy=0, done=1. stop in IDLE is ignored.
- start while busy is ignored.
- mask changes during a pass are ignored until the wrap. dwell and mode are fixed from start until return to IDLE.
- sel changes only in cycles where sel_en=0 (break-before-make). On entering IDLE, sel returns to 0.
- Single enabled channel, continuous mode: that channel repeats with a BLANK cycle between dwells.

## Timing
- All outputs are registered.
- start sampled at edge 0: sel_en=1 and busy=1 from cycle 1.
- Per channel: dwell' cycles of ACTIVE plus 1 BLANK cycle, where dwell' = max(dwell,1).
- Single pass over N channels: ACTIVE/BLANK occupy cycles 1 through N*(dwell'+1). done=1 and busy=0 in the following cycle.
- Empty-mask start: done=1 in cycle 1; busy stays 0.
- stop sampled at edge k: sel_en=0, busy=0, done=1 in cycle k+1; done=0 in cycle k+2.
- done never asserts for two consecutive cycles. busy=0 whenever done=1.

## Test plan
- Single pass, mask=0x0089, dwell=2, start at cycle 0:
  - sel=0 with sel_en=1 in cycles 1-2; blank in cycle 3.
  - sel=3 in cycles 4-5; blank in cycle 6.
  - sel=7 in cycles 7-8; blank in cycle 9.
  - Cycle 10: done=1, busy=0, sel=0.
- Continuous, mask=0x8001, dwell=0: sel sequence 0,(blank),15,(blank),0,(blank),15, each channel held 1 cycle; done never asserts.
- Continuous, mask=0x0010, then mask changed to 0x0000 mid-pass: sel=4 completes its dwell and blank; at the wrap, done=1 and the block returns to IDLE.
- stop asserted during the second dwell cycle of sel=3 (mask=0x0089, dwell=4): next cycle sel_en=0, sel=0, busy=0, done=1; the following cycle done=0.
- start with mask=0: done=1 in cycle 1, busy=0, sel_en never asserts. start pulsed while busy: scan sequence unchanged.
- rst_n driven low mid-ACTIVE, asynchronous to clk: sel, sel_en, busy and done go to 0 immediately. After release, no activity until the next start.
